if_fetch_buf: RTL and testbench
===============================

Name: if_fetch_buf

Overview:
- Parametrised successor of the single-register fetch stage: issues sequential instruction fetches to a pipelined instruction memory, buffers up to DEPTH returned {pc, inst} pairs in a FIFO, and presents them to ID over a valid/ready handshake.
- Handles redirect (branch/flush) by dropping in-flight responses.
- Sits between PC generation / imem and the ID stage.

Parameters:
ADDR_W, 32, PC and address width
INST_W, 32, instruction width
RESET_PC, 32'h1C000000, PC loaded on reset
DEPTH, 4, FIFO entries and maximum outstanding requests; power of two, ≥2

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request
imem_req_addr  out  ADDR_W  fetch address (current PC)
imem_resp_valid  in  1  in-order response, any latency ≥1
imem_resp_inst  in  INST_W  response data
redirect_valid  in  1  branch taken or flush
redirect_pc  in  ADDR_W  new fetch PC
out_valid  out  1  FIFO head valid
out_ready  in  1  ID accepts head
out_bus  out  ADDR_W+INST_W  {pc, inst}, pc in upper bits

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, resp_pc=RESET_PC; FIFO empty; outstanding=0, drop=0.
  - Outputs: out_valid=0, imem_req_valid=0, out_bus=0.
- Credit rule: imem_req_valid = !redirect_valid && (fifo_count + outstanding < DEPTH). A buffered FIFO slot therefore always exists for every response.
- Request fire (valid & ready): pc += 4 (wraps mod 2^ADDR_W); outstanding += 1.
- Response:
  - Every response decrements outstanding.
  - If drop>0: the response is discarded and drop decrements.
  - Otherwise {resp_pc, imem_resp_inst} is pushed into the FIFO and resp_pc += 4.
- Pop: out_valid & out_ready removes the head. out_bus is driven from the FIFO head (registered storage, no combinational path from imem).
- Latency: with a 1-cycle imem and out_ready=1, the first out_valid is 2 cycles after reset release. Steady state is 1 instruction/cycle.
- Redirect (redirect_valid=1), applied at the clock edge:
  - pc and resp_pc load redirect_pc.
  - The FIFO is cleared; any same-cycle pop is ignored.
  - drop = outstanding minus 1 if a non-dropped response arrives in the same cycle. A dropped same-cycle response also reduces drop by 1.
  - Request suppressed in the redirect cycle; fetch resumes the next cycle.
  - Back-to-back redirects: the last one wins; drop is recomputed each cycle.
- Full: FIFO count=DEPTH with out_ready=0 forces imem_req_valid=0. Push and pop in the same cycle when full is legal only for non-full counts, which the credit rule guarantees.
- Empty: out_valid=0; push and pop on an empty FIFO cannot coincide (the head is registered).
- Reset mid-operation: all state clears; later stale imem responses are the imem's responsibility (imem shares the reset).

Optional Feature:
- Macro IF_MISALIGN_EXC_EN.
- With the macro:
  - Extra output port out_exc (1 bit), aligned with out_bus.
  - If pc[1:0]!=0 after a redirect: no imem request is issued.
  - Once outstanding=0 and drop=0, a single entry {pc, 0} with out_exc=1 is pushed.
  - Fetch then halts until the next redirect.
- Without the macro: no out_exc port; low PC bits are passed to imem unchanged.

Decomposition:
- Package if_pkg:
  - RESET_PC default, INST_W/ADDR_W defaults.
  - typedef fetch_bus_t {pc, inst}.
  - Localparam for the PC increment (4).
- One sub-module: if_sync_fifo.
  - Parametrised DEPTH/width, with clear, push, pop, count, async active-low reset.
  - Credit, drop and PC logic stays in the top level.

Test Plan:
- Reset release, 1-cycle imem, out_ready=1 -> out_bus pcs 1C000000, 1C000004, 1C000008 on consecutive cycles; first out_valid 2 cycles after reset deasserts.
- out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0; FIFO holds pcs 1C000000..1C00000C; releasing out_ready drains them in order.
- Redirect to 1C000100 with 2 requests outstanding (3-cycle imem) -> both responses dropped; first out_bus pc after redirect = 1C000100; no stale entry visible.
- Redirect in the same cycle as a pop and a response -> FIFO empty next cycle; drop count correct; no duplicate or lost instruction after the target.
- Async reset asserted mid-stream with a full FIFO -> out_valid and imem_req_valid drop immediately; PC restarts at 1C000000.
- IF_MISALIGN_EXC_EN: redirect to 1C000102 -> no imem request; one entry with out_exc=1 and pc 1C000102; fetch halts until a redirect to 1C000200 resumes normal fetch.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared defaults and bundle type for the fetch buffer.
// Imported by if_fetch_buf and if_sync_fifo.
package if_pkg;

    localparam int          IF_ADDR_W   = 32;
    localparam int          IF_INST_W   = 32;
    localparam logic [31:0] IF_RESET_PC = 32'h1C00_0000;
    localparam int          PC_INC      = 4;

    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_INST_W-1:0] inst;
    } fetch_bus_t;

endpackage

// File: rtl/if_sync_fifo.sv
// if_sync_fifo: power-of-two synchronous FIFO with clear, registered head
// and an occupancy count; async active-low reset.
module if_sync_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: credit-limited sequential fetch into a DEPTH-entry buffer.
// Optional IF_MISALIGN_EXC_EN traps misaligned redirect targets (out_exc).
module if_fetch_buf
    import if_pkg::*;
#(
    parameter int                ADDR_W   = IF_ADDR_W,
    parameter int                INST_W   = IF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC),
    parameter int                DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDR_W-1:0]        imem_req_addr,
    input  logic                     imem_resp_valid,
    input  logic [INST_W-1:0]        imem_resp_inst,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef IF_MISALIGN_EXC_EN
    output logic                     out_exc,
`endif
    output logic [ADDR_W+INST_W-1:0] out_bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = ADDR_W + INST_W;
`ifdef IF_MISALIGN_EXC_EN
    localparam int FW = BW + 1;
`else
    localparam int FW = BW;
`endif
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     count;
    logic [CW:0]       in_use;
    logic              credit;
    logic              halt;
    logic              req_fire;
    logic              resp_keep;
    logic              resp_drop;
    logic              push;
    logic              pop;
    logic [FW-1:0]     push_data;
    logic [FW-1:0]     head;

`ifdef IF_MISALIGN_EXC_EN
    logic misaligned;
    logic halted;
    logic exc_push;

    assign misaligned = pc[1:0] != 2'b00;
    assign halt       = misaligned;
    // Trap entry waits until every old response has drained.
    assign exc_push   = misaligned && !halted && !redirect_valid
                     && outstanding == '0 && drop == '0
                     && count != CW'(DEPTH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted <= 1'b0;
        end else if (redirect_valid) begin
            halted <= 1'b0;
        end else if (exc_push) begin
            halted <= 1'b1;
        end
    end

    assign out_exc = head[FW-1];
`else
    assign halt = 1'b0;
`endif

    // Every issued request owns a FIFO slot, so responses never stall.
    assign in_use = {1'b0, count} + {1'b0, outstanding};
    assign credit = in_use < (CW+1)'(DEPTH);

    assign imem_req_valid = reset && !redirect_valid && credit && !halt;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_drop = imem_resp_valid && drop != '0;
    assign resp_keep = imem_resp_valid && drop == '0 && !redirect_valid;

    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign out_bus   = head[BW-1:0];

    always_comb begin
        push      = resp_keep;
        push_data = FW'({resp_pc, imem_resp_inst});
`ifdef IF_MISALIGN_EXC_EN
        if (exc_push) begin
            push      = 1'b1;
            push_data = {1'b1, pc, {INST_W{1'b0}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                pc      <= redirect_pc;
                resp_pc <= redirect_pc;
                drop    <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (req_fire) begin
                    pc <= pc + INC;
                end
                if (resp_keep) begin
                    resp_pc <= resp_pc + INC;
                end
                if (resp_drop) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    if_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_if_fetch_buf.sv
// tb_if_fetch_buf: directed and randomized checks of if_fetch_buf against a
// stream-level model (sequential pcs from reset/redirect target, inst = f(pc)).
`timescale 1ns/1ps
module tb_if_fetch_buf;
    import if_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_inst = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_bus;
`ifdef IF_MISALIGN_EXC_EN
    logic        out_exc;
`endif

    always #5 clk = ~clk;

    if_fetch_buf #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_inst  (imem_resp_inst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
`ifdef IF_MISALIGN_EXC_EN
        .out_exc         (out_exc),
`endif
        .out_bus         (out_bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          lat     = 1;
    bit          rand_lat = 1'b0;
    logic [31:0] salt;
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          last_due = -1;
    logic [31:0] exp_pc = RST_PC;
    bit          exp_halt = 1'b0;
    int          fires = 0;
    int          pops  = 0;
    logic        ov;
    logic [31:0] last_pop_pc = '0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: called just after a negedge, returns just after the next.
    task automatic step(input bit rdy, input bit qrdy, input bit redir,
                        input logic [31:0] rpc);
        bit          resp;
        int          n_out;
        int          l;
        int          due;
        fetch_bus_t  ob;
        out_ready      = rdy;
        imem_req_ready = qrdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        n_out = q_due.size();
        resp  = (n_out > 0) && (q_due[0] <= cyc);
        imem_resp_valid = resp;
        imem_resp_inst  = resp ? inst_of(q_addr[0]) : $urandom;
        if (resp) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        #1;
        ov = out_valid;
        if (redir) chk("req_in_redirect", imem_req_valid, 0);
        if (n_out >= DEPTH) chk("credit", imem_req_valid, 0);
`ifdef IF_MISALIGN_EXC_EN
        if (!redir && exp_pc[1:0] != 2'b00)
            chk("trap_no_req", imem_req_valid, 0);
`endif
        if (out_valid && rdy && !redir) begin
            pops++;
            ob = out_bus;
            last_pop_pc = ob.pc;
`ifdef IF_MISALIGN_EXC_EN
            if (exp_pc[1:0] != 2'b00) begin
                if (exp_halt) chk("pop_after_trap", out_valid, 0);
                else begin
                    chk("trap_exc", out_exc, 1);
                    chk("trap_bus", out_bus, {exp_pc, 32'h0});
                    exp_halt = 1'b1;
                end
            end else begin
                chk("out_exc", out_exc, 0);
                chk("out_bus", out_bus, {exp_pc, inst_of(exp_pc)});
                exp_pc += 4;
            end
`else
            chk("out_bus", out_bus, {exp_pc, inst_of(exp_pc)});
            exp_pc += 4;
`endif
        end
        if (imem_req_valid && qrdy) begin
            fires++;
            l   = rand_lat ? int'($urandom_range(1, 4)) : lat;
            due = cyc + l;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            q_addr.push_back(imem_req_addr);
            q_due.push_back(due);
        end
        if (redir) begin
            exp_pc   = rpc;
            exp_halt = 1'b0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic finish_reset();
        q_addr.delete();
        q_due.delete();
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        exp_pc   = RST_PC;
        exp_halt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        cyc      = 0;
        last_due = -1;
        fires    = 0;
        pops     = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        finish_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        salt = $urandom;
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_out_bus", out_bus, 0);

        // Latency and steady-state throughput with a 1-cycle imem.
        reset = 1'b1;
        lat   = 1;
        step(1, 1, 0, 0); chk("lat_c0", ov, 0);
        step(1, 1, 0, 0); chk("lat_c1", ov, 0);
        step(1, 1, 0, 0); chk("lat_c2", ov, 1);
        chk("first_pc", last_pop_pc, RST_PC);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("stream_pops", pops, 3);
        chk("stream_last_pc", last_pop_pc, 32'h1C00_0008);

        // Back-pressure: credits stop issue at DEPTH.
        do_reset();
        repeat (10) step(0, 1, 0, 0);
        chk("stall_fires", fires, 4);
        chk("stall_req_valid", imem_req_valid, 0);
        chk("stall_out_valid", ov, 1);
        repeat (4) step(1, 0, 0, 0);
        chk("drain_pops", pops, 4);
        chk("drain_last_pc", last_pop_pc, 32'h1C00_000C);
        step(0, 0, 0, 0);
        chk("drained", ov, 0);

        // Redirect with two requests in flight on a 3-cycle imem.
        do_reset();
        lat = 3;
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h1C00_0100);
        for (int i = 0; i < 20 && pops == 0; i++) step(1, 1, 0, 0);
        chk("redir_progress", pops > 0, 1);
        chk("redir_first_pc", last_pop_pc, 32'h1C00_0100);

        // Redirect coinciding with a pop and a live response.
        do_reset();
        lat = 1;
        repeat (6) step(1, 1, 0, 0);
        step(1, 1, 1, 32'h1C00_0040);
        chk("t4_ov_at_redirect", ov, 1);
        pops = 0;
        step(1, 1, 0, 0);
        chk("t4_empty", ov, 0);
        repeat (9) step(1, 1, 0, 0);
        chk("t4_pops", pops, 8);
        chk("t4_last_pc", last_pop_pc, 32'h1C00_005C);

        // Asynchronous reset while the buffer is full.
        do_reset();
        repeat (8) step(0, 1, 0, 0);
        chk("full_ov", ov, 1);
        #3 reset = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_req_valid", imem_req_valid, 0);
        chk("arst_out_bus", out_bus, 0);
        finish_reset();
        #1;
        chk("restart_addr", imem_req_addr, RST_PC);
        chk("restart_req", imem_req_valid, 1);
        repeat (5) step(1, 1, 0, 0);
        chk("restart_pops", pops, 3);
        chk("restart_last_pc", last_pop_pc, 32'h1C00_0008);

`ifdef IF_MISALIGN_EXC_EN
        // Misaligned target traps once, then fetch halts.
        do_reset();
        lat = 2;
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        pops = 0;
        step(0, 1, 1, 32'h1C00_0102);
        repeat (6) step(0, 1, 0, 0);
        chk("trap_ov", ov, 1);
        repeat (5) step(1, 1, 0, 0);
        chk("trap_pops", pops, 1);
        chk("trap_pc", last_pop_pc, 32'h1C00_0102);
        step(1, 1, 1, 32'h1C00_0200);
        repeat (6) step(1, 1, 0, 0);
        chk("resume_pops", pops, 4);
        chk("resume_last_pc", last_pop_pc, 32'h1C00_0208);
`endif

        // Randomized traffic, latency and redirects.
        do_reset();
        rand_lat = 1'b1;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tgt = $urandom & 32'hFFFF_FFFC;
`ifdef IF_MISALIGN_EXC_EN
            if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
`endif
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 49) == 0, tgt);
        end
        chk("rand_progress", pops > 50, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
